// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a glitch-free ratio change.
// A loaded ratio waits in a pending register and takes effect only on a period boundary.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | stopped; clk_out/tick low, cnt held at 0, pending ratio applied
// ST_RUN  | dividing; cnt walks 0..div_cur-1, pending ratio applied at wrap
module clk_div_prog #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_pend,
   output logic             div_err,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_out,
   output logic             tick
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] pend_val, pend_val_nxt;
   logic [CNT_W-1:0] cur_nxt;
   logic             pend_nxt;
   logic             err_nxt;
   logic             clk_nxt;
   logic             tick_nxt;

   logic             load_ok;
   logic             wrap;
   logic             apply;
   logic [CNT_W-1:0] n_eff;
   logic [CNT_W-1:0] hi_eff;
   logic [CNT_W-1:0] cnt_inc;

   assign load_ok = div_load && (div_val >= TWO);
   assign wrap    = (cnt == (div_cur - ONE));
   assign apply   = div_pend && ((state == ST_IDLE) || (en && wrap));
   assign cnt_inc = cnt + ONE;

   // The high-time of the period starting at this edge uses the ratio that
   // will be in effect for it, so the first period after a change is exact.
   assign n_eff  = apply ? pend_val : div_cur;
   assign hi_eff = (n_eff >> 1) + {{(CNT_W-1){1'b0}}, n_eff[0]};

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      clk_nxt      = 1'b0;
      tick_nxt     = 1'b0;
      cur_nxt      = n_eff;
      pend_nxt     = div_pend && !apply;
      pend_val_nxt = pend_val;
      err_nxt      = div_load && !load_ok;

      // A load coinciding with an apply becomes the next pending value.
      if (load_ok) begin
         pend_val_nxt = div_val;
         pend_nxt     = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (en) begin
               state_nxt = ST_RUN;
               clk_nxt   = 1'b1;
               tick_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt  = wrap ? '0 : cnt_inc;
               clk_nxt  = (cnt_nxt < hi_eff);
               tick_nxt = (cnt_nxt == '0);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         div_cur  <= DEF_N;
         pend_val <= '0;
         div_pend <= 1'b0;
         div_err  <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         div_cur  <= cur_nxt;
         pend_val <= pend_val_nxt;
         div_pend <= pend_nxt;
         div_err  <= err_nxt;
         clk_out  <= clk_nxt;
         tick     <= tick_nxt;
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a waveform-queue reference model predicts every
// cycle's outputs; a monitor compares them one time unit after each rising edge.
module tb_clk_div_prog;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] div_val;
   logic       div_load;
   logic       div_pend;
   logic       div_err;
   logic [7:0] div_cur;
   logic       clk_out;
   logic       tick;

   int checks = 0;
   int errors = 0;

   clk_div_prog #(.CNT_W(8), .DEF_DIV(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .div_pend (div_pend),
      .div_err  (div_err),
      .div_cur  (div_cur),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic clk_o;
      logic tk;
      logic pd;
      logic er;
      int   cur;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: a running period is a queue of output bits; an empty
   // queue marks the period boundary where a pending ratio may take effect.
   bit   m_run;
   bit   m_pend;
   int   m_cur;
   int   m_pv;
   logic wave[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_pend = 0;
      m_cur  = 6;
      m_pv   = 0;
      wave.delete();
   endtask

   task automatic build_period();
      wave.delete();
      for (int i = 0; i < m_cur; i++) wave.push_back(i < (m_cur + 1) / 2);
   endtask

   task automatic model_step(input logic e, input logic ld, input int v);
      exp_t x;
      x.er = ld && (v < 2);
      x.tk = 1'b0;
      x.clk_o = 1'b0;
      if (!m_run) begin
         if (m_pend) begin
            m_cur  = m_pv;
            m_pend = 0;
         end
         if (e) begin
            m_run = 1;
            build_period();
            x.clk_o = wave.pop_front();
            x.tk = 1'b1;
         end
      end else if (!e) begin
         m_run = 0;
         wave.delete();
      end else begin
         if (wave.size() == 0) begin
            if (m_pend) begin
               m_cur  = m_pv;
               m_pend = 0;
            end
            build_period();
            x.tk = 1'b1;
         end
         x.clk_o = wave.pop_front();
      end
      if (ld && v >= 2) begin
         m_pv   = v;
         m_pend = 1;
      end
      x.pd  = m_pend;
      x.cur = m_cur;
      exp_q.push_back(x);
   endtask

   task automatic step(input logic e, input logic ld, input int v);
      @(negedge clk);
      en       = e;
      div_load = ld;
      div_val  = 8'(v);
      model_step(e, ld, v);
   endtask

   always @(posedge clk) begin
      #1;
      if (reset && exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         chk("clk_out", int'(clk_out), int'(x.clk_o));
         chk("tick", int'(tick), int'(x.tk));
         chk("div_pend", int'(div_pend), int'(x.pd));
         chk("div_err", int'(div_err), int'(x.er));
         chk("div_cur", int'(div_cur), x.cur);
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_clk_out"}, int'(clk_out), 0);
      chk({tag, "_tick"}, int'(tick), 0);
      chk({tag, "_div_pend"}, int'(div_pend), 0);
      chk({tag, "_div_err"}, int'(div_err), 0);
      chk({tag, "_div_cur"}, int'(div_cur), 6);
   endtask

   initial begin
      bit found;
      reset    = 1'b0;
      en       = 1'b0;
      div_load = 1'b0;
      div_val  = '0;
      model_reset();
      #22;
      check_reset_values("rst");
      @(negedge clk);
      reset = 1'b1;

      // default ratio 6, then change to 5
      for (int i = 0; i < 14; i++) step(1, 0, 0);
      step(1, 1, 5);
      for (int i = 0; i < 16; i++) step(1, 0, 0);

      // last writer wins before the wrap
      step(1, 1, 2);
      step(1, 1, 9);
      for (int i = 0; i < 22; i++) step(1, 0, 0);

      // rejected loads
      step(1, 1, 1);
      step(1, 0, 0);
      step(1, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0);

      // 7 pending, 3 loaded exactly on the wrap edge
      step(1, 1, 7);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_run && wave.size() == 0) begin
            found = 1;
            break;
         end
         step(1, 0, 0);
      end
      chk("wrap_edge_found", int'(found), 1);
      step(1, 1, 3);
      for (int i = 0; i < 18; i++) step(1, 0, 0);

      // stop mid-period, pending applied while stopped, restart
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 1, 4);
      step(0, 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0);

      // asynchronous reset while running
      @(posedge clk);
      #3;
      en       = 1'b0;
      div_load = 1'b0;
      reset    = 1'b0;
      #1;
      check_reset_values("async_rst");
      chk("queue_drained", exp_q.size(), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) step(1, 0, 0);

      // randomized phase
      for (int i = 0; i < 800; i++) begin
         logic e, ld;
         int   v;
         e  = ($urandom_range(0, 19) != 0);
         ld = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) v = $urandom_range(0, 40);
         else v = $urandom_range(0, 12);
         step(e, ld, v);
      end

      @(negedge clk);
      @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
